cim_tile_resp: RTL and testbench

CIM_TILE_RESP -- requirements
Module: cim_tile_resp

---
 rtl/cim_tile_resp_if.sv | 56 +++++
 rtl/cim_tile_resp.sv | 219 +++++++++++++++++++++
 tb/tb_cim_tile_resp.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cim_tile_resp_if.sv
`default_nettype none
// ============================================================================
//  Module   : cim_tile_resp_if
//  Purpose  : Bundles the compute-in-memory tile's host-facing signals:
//             input-buffer write port, ready, output-buffer read port,
//             weight programming port and the protocol-error flag.
//  Ports    : (interface signals)
//             i_cim_we / i_cim_addr / i_cim_data   input word writes
//             o_cim_ready                          tile idle, results valid
//             i_obuf_addr / o_obuf_data            output buffer read
//             i_w_we / i_w_row / i_w_col / i_w_data weight programming
//             o_proto_err                          sticky protocol error
//  Modports : master (host side), slave (tile side)
//  Revision : 1.0  initial release
// ============================================================================
interface cim_tile_resp_if #(
   parameter int XBAR_SIZE      = 512,
   parameter int DATA_SIZE      = 8,
   parameter int BUS_WIDTH      = 16,
   parameter int OBUF_BUS_WIDTH = 46
) ();
   localparam int ELEM_PER_WORD     = BUS_WIDTH / DATA_SIZE;
   localparam int NUM_ADDR          = XBAR_SIZE / ELEM_PER_WORD;
   localparam int OBUF_DATA_SIZE    = (DATA_SIZE == 1) ? $clog2(XBAR_SIZE)
                                                       : 2 * DATA_SIZE + $clog2(XBAR_SIZE);
   localparam int NUM_CHANNELS      = OBUF_BUS_WIDTH / OBUF_DATA_SIZE;
   localparam int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE;
   localparam int NUM_ADDR_OBUF     = (ELEMENTS_PER_TILE + NUM_CHANNELS - 1) / NUM_CHANNELS;

   logic                                         i_cim_we;
   logic [$clog2(NUM_ADDR)-1:0]                  i_cim_addr;
   logic [BUS_WIDTH-1:0]                         i_cim_data;
   logic                                         o_cim_ready;
   logic [$clog2(NUM_ADDR_OBUF)-1:0]             i_obuf_addr;
   logic [NUM_CHANNELS-1:0][OBUF_DATA_SIZE-1:0]  o_obuf_data;
   logic                                         i_w_we;
   logic [$clog2(XBAR_SIZE)-1:0]                 i_w_row;
   logic [$clog2(ELEMENTS_PER_TILE)-1:0]         i_w_col;
   logic [DATA_SIZE-1:0]                         i_w_data;
   logic                                         o_proto_err;

   modport master (
      output i_cim_we, i_cim_addr, i_cim_data,
      output i_obuf_addr,
      output i_w_we, i_w_row, i_w_col, i_w_data,
      input  o_cim_ready, o_obuf_data, o_proto_err
   );

   modport slave (
      input  i_cim_we, i_cim_addr, i_cim_data,
      input  i_obuf_addr,
      input  i_w_we, i_w_row, i_w_col, i_w_data,
      output o_cim_ready, o_obuf_data, o_proto_err
   );
endinterface
`default_nettype wire

// File: rtl/cim_tile_resp.sv
`default_nettype none
// ============================================================================
//  Module   : cim_tile_resp
//  Purpose  : Compute-in-memory crossbar tile. A full input vector is written
//             word by word; the write to the last word starts a row-serial
//             multiply-accumulate over the weight crossbar (one row per
//             cycle), followed by a fixed drain period, after which the
//             column sums are published to a channelised output buffer.
//  Ports    : clk  - sole clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - cim_tile_resp_if.slave (input writes, ready, output
//                    buffer reads, weight programming, protocol error)
//  Options  : CIM_TILE_PROTO_CHECK_EN - when defined, builds a sticky flag
//             that records any input/weight write attempted while busy.
//             When undefined, o_proto_err is tied to 0.
//  Notes    : The interface instance must carry the same XBAR_SIZE,
//             DATA_SIZE, BUS_WIDTH and OBUF_BUS_WIDTH as this module.
//  Revision : 1.0  initial release
// ============================================================================
module cim_tile_resp #(
   parameter int XBAR_SIZE       = 512,
   parameter int DATA_SIZE       = 8,
   parameter int BUS_WIDTH       = 16,
   parameter int OBUF_BUS_WIDTH  = 46,
   parameter int COMPUTE_LATENCY = 4
) (
   input  logic            clk,
   input  logic            rst,
   cim_tile_resp_if.slave  bus
);
   // ------------------------------------------------------------------------
   // Derived geometry
   // ------------------------------------------------------------------------
   localparam int ELEM_PER_WORD     = BUS_WIDTH / DATA_SIZE;
   localparam int NUM_ADDR          = XBAR_SIZE / ELEM_PER_WORD;
   localparam int OBUF_DATA_SIZE    = (DATA_SIZE == 1) ? $clog2(XBAR_SIZE)
                                                       : 2 * DATA_SIZE + $clog2(XBAR_SIZE);
   localparam int NUM_CHANNELS      = OBUF_BUS_WIDTH / OBUF_DATA_SIZE;
   localparam int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE;
   localparam int NUM_ADDR_OBUF     = (ELEMENTS_PER_TILE + NUM_CHANNELS - 1) / NUM_CHANNELS;

   localparam int ADDR_W  = $clog2(NUM_ADDR);
   localparam int ROW_W   = $clog2(XBAR_SIZE);
   localparam int COL_W   = $clog2(ELEMENTS_PER_TILE);
   localparam int OADDR_W = $clog2(NUM_ADDR_OBUF);
   localparam int DRN_W   = (COMPUTE_LATENCY > 1) ? $clog2(COMPUTE_LATENCY) : 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDR - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(XBAR_SIZE - 1);
   localparam logic [DRN_W-1:0]  LAST_DRN  = DRN_W'(COMPUTE_LATENCY - 1);
   localparam logic [COL_W:0]    NUM_COLS  = (COL_W + 1)'(ELEMENTS_PER_TILE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   logic [BUS_WIDTH-1:0]       in_mem   [NUM_ADDR];
   logic [DATA_SIZE-1:0]       in_elem  [XBAR_SIZE];
   logic [DATA_SIZE-1:0]       w_mem    [XBAR_SIZE][ELEMENTS_PER_TILE];
   logic [OBUF_DATA_SIZE-1:0]  acc      [ELEMENTS_PER_TILE];
   logic [OBUF_DATA_SIZE-1:0]  prod     [ELEMENTS_PER_TILE];
   logic [OBUF_DATA_SIZE-1:0]  obuf_mem [ELEMENTS_PER_TILE];

   // Every encodable read address gets a view row; rows and channels that
   // fall outside the tile are hard-wired to zero.
   logic [NUM_CHANNELS-1:0][OBUF_DATA_SIZE-1:0] rd_view [2**OADDR_W];
   logic [NUM_CHANNELS-1:0][OBUF_DATA_SIZE-1:0] rd_data;

   state_t                state;
   logic [ROW_W-1:0]      row_cnt;
   logic [DRN_W-1:0]      drn_cnt;
   logic                  ready;
   logic                  idle;
   logic                  col_ok;
   logic [DATA_SIZE-1:0]  cur_in;

   assign idle   = (state == ST_IDLE);
   assign col_ok = ({1'b0, bus.i_w_col} < NUM_COLS);
   assign cur_in = in_elem[row_cnt];

   // ------------------------------------------------------------------------
   // Input and weight memories: not reset, written only while idle. A write
   // coinciding with rst is dropped so reset fully dominates that cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst && idle && bus.i_cim_we) begin
         in_mem[bus.i_cim_addr] <= bus.i_cim_data;
      end
      if (!rst && idle && bus.i_w_we && col_ok) begin
         w_mem[bus.i_w_row][bus.i_w_col] <= bus.i_w_data;
      end
   end

   // Row r lives in word r/ELEM_PER_WORD at lane r%ELEM_PER_WORD.
   for (genvar r = 0; r < XBAR_SIZE; r++) begin : g_in_elem
      assign in_elem[r] = in_mem[r / ELEM_PER_WORD][(r % ELEM_PER_WORD) * DATA_SIZE +: DATA_SIZE];
   end

   // Per-column product of the current row's input and weight.
   for (genvar c = 0; c < ELEMENTS_PER_TILE; c++) begin : g_prod
      if (DATA_SIZE == 1) begin : g_and
         assign prod[c] = OBUF_DATA_SIZE'(cur_in & w_mem[row_cnt][c]);
      end else begin : g_mul
         assign prod[c] = OBUF_DATA_SIZE'(cur_in) * OBUF_DATA_SIZE'(w_mem[row_cnt][c]);
      end
   end

   for (genvar a = 0; a < 2**OADDR_W; a++) begin : g_rd_addr
      for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_rd_ch
         if ((a < NUM_ADDR_OBUF) && (a * NUM_CHANNELS + ch < ELEMENTS_PER_TILE)) begin : g_col
            assign rd_view[a][ch] = obuf_mem[a * NUM_CHANNELS + ch];
         end else begin : g_zero
            assign rd_view[a][ch] = '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM, accumulators, output buffer and read register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         row_cnt <= '0;
         drn_cnt <= '0;
         ready   <= 1'b1;
         rd_data <= '0;
         for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
            obuf_mem[c] <= '0;
         end
      end else begin
         // Read port is live in every state; while busy it shows the
         // previously published result because obuf_mem is untouched.
         rd_data <= rd_view[bus.i_obuf_addr];

         case (state)
            ST_IDLE: begin
               if (bus.i_cim_we && (bus.i_cim_addr == LAST_ADDR)) begin
                  state   <= ST_ACCUM;
                  row_cnt <= '0;
                  ready   <= 1'b0;
                  for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
                     acc[c] <= '0;
                  end
               end
            end

            ST_ACCUM: begin
               for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
                  acc[c] <= acc[c] + prod[c];
               end
               if (row_cnt == LAST_ROW) begin
                  row_cnt <= '0;
                  if (COMPUTE_LATENCY == 0) begin
                     // No drain period: publish including the final row.
                     state <= ST_IDLE;
                     ready <= 1'b1;
                     for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
                        obuf_mem[c] <= acc[c] + prod[c];
                     end
                  end else begin
                     state   <= ST_DRAIN;
                     drn_cnt <= '0;
                  end
               end else begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end

            ST_DRAIN: begin
               if (drn_cnt == LAST_DRN) begin
                  state   <= ST_IDLE;
                  ready   <= 1'b1;
                  drn_cnt <= '0;
                  for (int c = 0; c < ELEMENTS_PER_TILE; c++) begin
                     obuf_mem[c] <= acc[c];
                  end
               end else begin
                  drn_cnt <= drn_cnt + 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.o_cim_ready = ready;
   assign bus.o_obuf_data = rd_data;

   // ------------------------------------------------------------------------
   // Optional protocol checker
   // ------------------------------------------------------------------------
`ifdef CIM_TILE_PROTO_CHECK_EN
   logic proto_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if (!idle && (bus.i_cim_we || bus.i_w_we)) begin
         proto_err <= 1'b1;
      end
   end

   assign bus.o_proto_err = proto_err;
`else
   assign bus.o_proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cim_tile_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cim_tile_resp
//  Purpose  : Self-checking bench for cim_tile_resp (16x4 tile, 4-bit data).
//             A driver issues directed and random workloads and pushes the
//             expected read data and busy-window lengths into queues; a
//             monitor pops and compares whenever the tile returns data or
//             ends a busy window.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cim_tile_resp;
   localparam int XS   = 16;
   localparam int DS   = 4;
   localparam int BW   = 8;
   localparam int OBW  = 24;
   localparam int LAT  = 4;
   localparam int NA   = 8;
   localparam int EPT  = 4;
   localparam int ODS  = 12;
   localparam int NCH  = 2;
   localparam int RUN  = XS + LAT;

`ifdef CIM_TILE_PROTO_CHECK_EN
   localparam logic PROTO_EN = 1'b1;
`else
   localparam logic PROTO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cim_tile_resp_if #(
      .XBAR_SIZE(XS), .DATA_SIZE(DS), .BUS_WIDTH(BW), .OBUF_BUS_WIDTH(OBW)
   ) bus ();

   cim_tile_resp #(
      .XBAR_SIZE(XS), .DATA_SIZE(DS), .BUS_WIDTH(BW), .OBUF_BUS_WIDTH(OBW),
      .COMPUTE_LATENCY(LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: plain matrices and a dot product per column.
   int model_w    [XS][EPT];
   int model_in   [XS];
   int model_obuf [EPT];
   bit tb_busy = 1'b0;

   logic [NCH-1:0][ODS-1:0] exp_rd_q [$];
   int                      exp_len_q[$];
   logic                    rd_req = 1'b0;
   int                      low_cnt = 0;

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   always @(posedge clk) begin : mon
      logic                    req_at_edge;
      logic [NCH-1:0][ODS-1:0] e;
      int                      want_len;
      req_at_edge = rd_req;
      #1;
      if (req_at_edge) begin
         n_cmp++;
         if (exp_rd_q.size() == 0) begin
            n_err++;
            $display("FAIL obuf_read: got %h with no expected entry", bus.o_obuf_data);
         end else begin
            e = exp_rd_q.pop_front();
            if (bus.o_obuf_data !== e) begin
               n_err++;
               $display("FAIL obuf_read: got %h want %h", bus.o_obuf_data, e);
            end
         end
      end
      if (bus.o_cim_ready === 1'b0) begin
         low_cnt++;
      end else if (low_cnt > 0) begin
         n_cmp++;
         if (exp_len_q.size() == 0) begin
            n_err++;
            $display("FAIL busy_len: got %0d with no expected entry", low_cnt);
         end else begin
            want_len = exp_len_q.pop_front();
            if (low_cnt != want_len) begin
               n_err++;
               $display("FAIL busy_len: got %0d want %0d", low_cnt, want_len);
            end
         end
         low_cnt = 0;
      end
   end

   // ------------------------------------------------------------------------
   // Driver helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic model_run();
      for (int c = 0; c < EPT; c++) begin
         int s;
         s = 0;
         for (int r = 0; r < XS; r++) s += model_in[r] * model_w[r][c];
         model_obuf[c] = s % (1 << ODS);
      end
   endtask

   task automatic wr_word(input int a, input logic [BW-1:0] d);
      bus.i_cim_addr = 3'(a);
      bus.i_cim_data = d;
      bus.i_cim_we   = 1'b1;
      tick();
      bus.i_cim_we   = 1'b0;
      if (!tb_busy) begin
         model_in[2*a]   = int'(d[3:0]);
         model_in[2*a+1] = int'(d[7:4]);
         if (a == NA - 1) tb_busy = 1'b1;
      end
   endtask

   task automatic wr_w(input int r, input int c, input int d);
      bus.i_w_row  = 4'(r);
      bus.i_w_col  = 2'(c);
      bus.i_w_data = 4'(d);
      bus.i_w_we   = 1'b1;
      tick();
      bus.i_w_we   = 1'b0;
      if (!tb_busy) model_w[r][c] = d;
   endtask

   task automatic trigger(input logic [BW-1:0] d, input int len);
      exp_len_q.push_back(len);
      wr_word(NA - 1, d);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (bus.o_cim_ready === 1'b1) done = 1'b1;
         else tick();
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_idle: ready still %b after 100 cycles, want 1", bus.o_cim_ready);
      end
      tb_busy = 1'b0;
      model_run();
   endtask

   task automatic rd(input int a);
      logic [NCH-1:0][ODS-1:0] e;
      for (int ch = 0; ch < NCH; ch++) e[ch] = ODS'(model_obuf[a*NCH+ch]);
      exp_rd_q.push_back(e);
      bus.i_obuf_addr = 1'(a);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic load_w_const(input int v);
      for (int r = 0; r < XS; r++)
         for (int c = 0; c < EPT; c++) wr_w(r, c, v);
   endtask

   task automatic run_and_read(input logic [BW-1:0] last_word);
      trigger(last_word, RUN);
      wait_idle();
      rd(0);
      rd(1);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin : stim
      bus.i_cim_we    = 1'b0;
      bus.i_cim_addr  = '0;
      bus.i_cim_data  = '0;
      bus.i_obuf_addr = '0;
      bus.i_w_we      = 1'b0;
      bus.i_w_row     = '0;
      bus.i_w_col     = '0;
      bus.i_w_data    = '0;
      for (int c = 0; c < EPT; c++) model_obuf[c] = 0;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_ready", 32'(bus.o_cim_ready), 32'd1);
      chk("reset_proto_err", 32'(bus.o_proto_err), 32'd0);
      chk("reset_obuf", 32'(bus.o_obuf_data), 32'd0);
      rst = 1'b0;
      tick();
      rd(1);

      // All weights 1, all inputs 15 -> every column 240
      load_w_const(1);
      for (int a = 0; a < NA - 1; a++) wr_word(a, 8'hFF);
      run_and_read(8'hFF);

      // Non-trigger writes keep the tile idle and the results unchanged
      for (int a = 0; a < NA - 1; a++) begin
         wr_word(a, 8'($urandom));
         chk("ready_no_trigger", 32'(bus.o_cim_ready), 32'd1);
      end
      repeat (2) tick();
      chk("ready_no_trigger_late", 32'(bus.o_cim_ready), 32'd1);
      rd(0);
      trigger(8'($urandom), RUN);
      chk("ready_falls", 32'(bus.o_cim_ready), 32'd0);
      wait_idle();
      rd(0);
      rd(1);

      // Maximum operands -> 3600 per column, no wrap
      load_w_const(15);
      for (int a = 0; a < NA - 1; a++) wr_word(a, 8'hFF);
      run_and_read(8'hFF);

      // Identity weights, in[r] = r -> columns 0,1,2,3
      for (int r = 0; r < XS; r++)
         for (int c = 0; c < EPT; c++) wr_w(r, c, (r == c) ? 1 : 0);
      for (int a = 0; a < NA - 1; a++) wr_word(a, {4'(2*a+1), 4'(2*a)});
      run_and_read({4'(2*NA-1), 4'(2*NA-2)});

      // Random workloads, including a word rewritten before the trigger
      for (int t = 0; t < 4; t++) begin
         for (int r = 0; r < XS; r++)
            for (int c = 0; c < EPT; c++) wr_w(r, c, int'($urandom_range(0, 15)));
         for (int a = 0; a < NA - 1; a++) wr_word(a, 8'($urandom));
         wr_word(int'($urandom_range(0, NA - 2)), 8'($urandom));
         run_and_read(8'($urandom));
      end

      // Reset during accumulation row 5 aborts; rerun reproduces 240
      load_w_const(1);
      for (int a = 0; a < NA - 1; a++) wr_word(a, 8'hFF);
      trigger(8'hFF, 6);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tb_busy = 1'b0;
      for (int c = 0; c < EPT; c++) model_obuf[c] = 0;
      chk("abort_ready", 32'(bus.o_cim_ready), 32'd1);
      rd(0);
      rd(1);
      run_and_read(8'hFF);

      // Writes while busy are ignored and flagged when the checker exists
      trigger(8'hFF, RUN);
      rd(1);
      tick();
      wr_w(0, 0, 7);
      chk("proto_err_accum", 32'(bus.o_proto_err), 32'(PROTO_EN));
      repeat (14) tick();
      wr_word(NA - 1, 8'h00);
      chk("proto_err_drain", 32'(bus.o_proto_err), 32'(PROTO_EN));
      wait_idle();
      rd(0);
      rd(1);
      chk("proto_err_sticky", 32'(bus.o_proto_err), 32'(PROTO_EN));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("proto_err_cleared", 32'(bus.o_proto_err), 32'd0);

      repeat (3) tick();
      chk("pending_reads", 32'(exp_rd_q.size()), 32'd0);
      chk("pending_busy_windows", 32'(exp_len_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
